// File: rtl/spd_pkg.sv
// rtl/spd_pkg.sv - shared defaults and control state type for serial_pattern_detector
package spd_pkg;

    localparam int         SPD_PAT_W_DEF   = 4;
    localparam logic [3:0] SPD_PAT_RST_DEF = 4'b1001;
    localparam int         SPD_CNT_W_DEF   = 8;

    // FILL: not enough bits gathered to complete a pattern; ARMED: next accepted bit may match
    typedef enum logic {
        SPD_FILL,
        SPD_ARMED
    } spd_state_t;

endpackage

// File: rtl/spd_sat_counter.sv
// rtl/spd_sat_counter.sv - generic saturating counter with clear priority over increment
module spd_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // clear wins over increment; increment stops at all-ones instead of wrapping
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/serial_pattern_detector.sv
// rtl/serial_pattern_detector.sv - runtime-loadable serial pattern detector; match counter built only with SPD_MATCH_CNT_EN
module serial_pattern_detector
    import spd_pkg::*;
#(
    parameter int               PAT_W   = SPD_PAT_W_DEF,
    parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(SPD_PAT_RST_DEF),
    parameter int               CNT_W   = SPD_CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             i,
    input  logic             pattern_load,
    input  logic [PAT_W-1:0] pattern_in,
    input  logic             overlap_en,
    input  logic             count_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] pattern_q
);

    localparam int               FW       = $clog2(PAT_W + 1);
    localparam logic [FW-1:0]    FILL_MAX = FW'(PAT_W);
    localparam logic [FW-1:0]    ARM_AT   = FW'(PAT_W - 2);

    spd_state_t       state_q, state_d;
    logic [PAT_W-1:0] history_q, history_d;
    logic [FW-1:0]    fill_q, fill_d;
    logic [PAT_W-1:0] pattern_d;
    logic             match_d;
    logic [PAT_W-1:0] shifted;

    assign shifted = {history_q[PAT_W-2:0], i};

    // state register; reset drops any partial match and restores the reset pattern
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= SPD_FILL;
            history_q <= '0;
            fill_q    <= '0;
            pattern_q <= PAT_RST;
            match     <= 1'b0;
        end else begin
            state_q   <= state_d;
            history_q <= history_d;
            fill_q    <= fill_d;
            pattern_q <= pattern_d;
            match     <= match_d;
        end
    end

    // next-state: a load beats an incoming bit; ARMED means enough history to complete a match
    always_comb begin
        state_d   = state_q;
        history_d = history_q;
        fill_d    = fill_q;
        pattern_d = pattern_q;
        match_d   = 1'b0;
        if (pattern_load) begin
            pattern_d = pattern_in;
            history_d = '0;
            fill_d    = '0;
            state_d   = SPD_FILL;
        end else if (valid_in) begin
            history_d = shifted;
            fill_d    = (fill_q == FILL_MAX) ? fill_q : fill_q + FW'(1);
            if ((state_q == SPD_ARMED) && (shifted == pattern_q)) begin
                match_d = 1'b1;
                if (!overlap_en) begin
                    history_d = '0;
                    fill_d    = '0;
                    state_d   = SPD_FILL;
                end
            end else if ((state_q == SPD_FILL) && (fill_q == ARM_AT)) begin
                state_d = SPD_ARMED;
            end
        end
    end

`ifdef SPD_MATCH_CNT_EN
    spd_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (match),
        .clr   (count_clr),
        .count (match_count)
    );
`else
    logic unused_count_clr;
    assign unused_count_clr = count_clr;
    assign match_count      = '0;
`endif

endmodule

// File: tb/tb_serial_pattern_detector.sv
// tb/tb_serial_pattern_detector.sv - scoreboard bench for serial_pattern_detector
module tb_serial_pattern_detector;

    logic       clock = 1'b0;
    logic       reset;
    logic       valid_in;
    logic       i;
    logic       pattern_load;
    logic [3:0] pattern_in;
    logic       overlap_en;
    logic       count_clr;
    logic       match, match2;
    logic [7:0] match_count;
    logic [1:0] match_count2;
    logic [3:0] pattern_q, pattern_q2;

    always #5 clock = ~clock;

    serial_pattern_detector dut (
        .clock        (clock),
        .reset        (reset),
        .valid_in     (valid_in),
        .i            (i),
        .pattern_load (pattern_load),
        .pattern_in   (pattern_in),
        .overlap_en   (overlap_en),
        .count_clr    (count_clr),
        .match        (match),
        .match_count  (match_count),
        .pattern_q    (pattern_q)
    );

    serial_pattern_detector #(.CNT_W(2)) dut2 (
        .clock        (clock),
        .reset        (reset),
        .valid_in     (valid_in),
        .i            (i),
        .pattern_load (pattern_load),
        .pattern_in   (pattern_in),
        .overlap_en   (overlap_en),
        .count_clr    (count_clr),
        .match        (match2),
        .match_count  (match_count2),
        .pattern_q    (pattern_q2)
    );

    int checks = 0;
    int errors = 0;

    // reference state: accepted bits since the last clear, oldest first
    bit   bits[$];
    bit   sb[$];
    logic [3:0] m_pat  = 4'b1001;
    int   m_cnt  = 0;
    int   m_cnt2 = 0;
    bit   m_prev = 0;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input bit v, input bit b, input bit ld, input logic [3:0] pin,
                        input bit ov, input bit clr, input bit rst);
        bit         m;
        logic [3:0] w;
        int         n;
        reset = rst; valid_in = v; i = b; pattern_load = ld;
        pattern_in = pin; overlap_en = ov; count_clr = clr;
        m = 0;
        if (rst) begin
            bits.delete();
            m_pat = 4'b1001; m_cnt = 0; m_cnt2 = 0;
        end else begin
            if (clr) begin
                m_cnt = 0; m_cnt2 = 0;
            end else if (m_prev) begin
                if (m_cnt < 255) m_cnt++;
                if (m_cnt2 < 3) m_cnt2++;
            end
            if (ld) begin
                m_pat = pin;
                bits.delete();
            end else if (v) begin
                bits.push_back(b);
                n = bits.size();
                if (n >= 4) begin
                    for (int k = 0; k < 4; k++) w[3-k] = bits[n-4+k];
                    if (w == m_pat) begin
                        m = 1;
                        if (!ov) bits.delete();
                    end
                end
                while (bits.size() > 4) void'(bits.pop_front());
            end
        end
        m_prev = m;
        sb.push_back(m);
        @(posedge clock);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 0, 1);
        end else begin
            bit e;
            e = sb.pop_front();
            check("match", int'(match), int'(e));
            check("match_w2", int'(match2), int'(e));
        end
        check("pattern_q", int'(pattern_q), int'(m_pat));
`ifdef SPD_MATCH_CNT_EN
        check("match_count", int'(match_count), m_cnt);
        check("match_count_w2", int'(match_count2), m_cnt2);
`else
        check("match_count", int'(match_count), 0);
        check("match_count_w2", int'(match_count2), 0);
`endif
    endtask

    task automatic stream(input logic [15:0] s, input int len, input bit ov);
        for (int k = len - 1; k >= 0; k--) step(1, s[k], 0, 4'h0, ov, 0, 0);
    endtask

    initial begin
        logic [8:0] gap_v;
        logic [8:0] gap_b;
        gap_v = 9'b101010011;
        gap_b = 9'b110101111;

        // reset state
        step(0, 0, 0, 4'h0, 1, 0, 1);
        step(0, 0, 0, 4'h0, 1, 0, 1);
        step(0, 0, 0, 4'h0, 1, 0, 0);

        // overlapping 1001001: pulses after bits 4 and 7
        stream(16'b1001001, 7, 1);
        step(0, 1, 0, 4'h0, 1, 0, 0);
        step(0, 1, 0, 4'h0, 1, 0, 0);

        // non-overlapping: single pulse
        step(0, 0, 1, 4'b1001, 0, 1, 0);
        stream(16'b1001001, 7, 0);
        step(0, 1, 0, 4'h0, 0, 0, 0);
        step(0, 1, 0, 4'h0, 0, 0, 0);

        // pattern 0000: fill guard, then back-to-back pulses
        step(1, 1, 1, 4'b0000, 1, 0, 0);
        stream(16'b0, 7, 1);
        step(0, 0, 0, 4'h0, 1, 0, 0);

        // valid gaps with i=1 in the gaps
        step(0, 0, 1, 4'b1001, 1, 1, 0);
        for (int k = 8; k >= 0; k--) step(gap_v[k], gap_b[k], 0, 4'h0, 1, 0, 0);
        step(0, 0, 0, 4'h0, 1, 0, 0);

        // saturation of the narrow counter, then clear alongside a match pulse
        step(0, 0, 1, 4'b1001, 1, 1, 0);
        stream(16'b1001001001001, 13, 1);
        step(0, 0, 0, 4'h0, 1, 0, 0);
        stream(16'b001, 3, 1);
        step(0, 0, 0, 4'h0, 1, 1, 0);
        step(0, 0, 0, 4'h0, 1, 0, 0);

        // reset mid-stream loses the partial match
        stream(16'b100, 3, 1);
        step(0, 0, 0, 4'h0, 1, 0, 1);
        step(1, 1, 0, 4'h0, 1, 0, 0);
        step(0, 0, 0, 4'h0, 1, 0, 0);

        // random mix
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 40) == 0, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 60) == 0,
                 $urandom_range(0, 150) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
